pwm_mod: RTL and testbench
==========================

# pwm_mod

Center-aligned PWM modulator in the modulation chain. It consumes the free-running signed Q1.7 sample stream from the signal generator (one sample per `clk`) and converts it into a complementary gate-drive pair `pwm_h`/`pwm_l`. It uses symmetric regular sampling on a triangular carrier, with optional dead-time insertion. Its outputs drive the half-bridge or the output filter directly.

## Interface
- `DEAD`, 4: dead-time length in clk cycles; legal range 1..15; used only with `PWM_DEADTIME_EN`.
- `clk  in  1`: sole clock; all state updates on rising edge.
- `rst_n  in  1`: asynchronous, active-low reset.
- `en  in  1`: run enable; level-sensitive, sampled on `clk`.
- `x  in  8`: signed Q1.7 modulating sample, valid every cycle.
- `pwm_h  out  1`: high-side drive, registered.
- `pwm_l  out  1`: low-side drive, registered.
- `sync  out  1`: one-cycle pulse marking carrier valley and duty update, registered.

## Operation
- **Carrier:** 8-bit counter `cnt` with direction flag.
  - Sequence is 0,1,…,255,254,…,1,0,1,…
  - Period is 510 cycles; 0 and 255 each occur once per period.
- **Duty latch:** on an enabled edge with `cnt==0`, load `duty_q <= {~x[7], x[6:0]}`, i.e. x+128 offset-binary.
  - `x` is ignored on all other cycles.
- **Compare:** `raw_q <= (duty_q > cnt)`, registered.
  - High time per period is 2d−1 cycles for d≥1, and 0 for d=0.
  - x=0 gives 255/510; x=127 gives 509/510; x=−128 gives 0.
- **Outputs without dead time:** `pwm_h = raw_q`, `pwm_l = ~raw_q`, both registered, both forced 0 when disabled.
- **`sync`:** high for exactly one cycle, in the cycle after each edge where `cnt==0` is consumed, i.e. coincident with the new `duty_q`.
- **Enable:**
  - When `en`=0, the next edge forces `cnt=0`, direction up, `pwm_h=pwm_l=0`, `sync=0`, FSM to IDLE; `duty_q` is held.
  - The first enabled edge after re-enable is a valley: `duty_q` loads and `sync` fires.
- **Reset values:** `cnt=0`, dir=up, `duty_q=8'h80`, `raw_q=0`, `pwm_h=0`, `pwm_l=0`, `sync=0`, state IDLE, dead timer 0.
  - Reset asserted mid-period takes effect immediately (async), with no glitch on either output beyond going low.
- **Invariant:** `pwm_h` and `pwm_l` are never both 1 in any cycle.

## Timing
- Latency from `cnt` value to output pin level is 2 cycles: one for the compare register, one for the output register.
- Latency from `x` sampled at valley edge E to first effect on pins is E+2 cycles.
- A mid-period change of `x` has no effect until the next valley.
- **Dead-time FSM** (`PWM_DEADTIME_EN` only):
  - States: IDLE, DEAD, DRIVE.
  - IDLE→DEAD when `en`=1; timer loads `DEAD`.
  - DEAD: both outputs 0; timer decrements each cycle; when the timer expires after exactly `DEAD` cycles, go to DRIVE.
  - DRIVE: `pwm_h=raw_q`, `pwm_l=~raw_q`.
  - Any toggle of `raw_q` in DRIVE goes to DEAD and reloads the timer.
  - A toggle of `raw_q` while in DEAD reloads the timer, so pulses ≤`DEAD` cycles are swallowed.
  - Any state goes to IDLE on `en`=0.
- Each output's high time is shortened by `DEAD` cycles relative to `raw_q`.

## Configuration
- Macro: `PWM_DEADTIME_EN`.
- **Defined:** dead-time FSM and timer are present, with behaviour as in Timing.
- **Undefined:** no FSM, timer or `DEAD` logic.
  - Outputs follow `raw_q` directly: `pwm_h=raw_q&en_q`, `pwm_l=~raw_q&en_q`.
  - The complementary edges switch in the same cycle.

## Structure
- **Shared package `pwm_pkg`:**
  - Dead-time FSM state enum (IDLE, DEAD, DRIVE).
  - `PWM_DATA_W=8`, `PWM_CNT_MAX=8'hFF`, `PWM_DUTY_MID=8'h80`.
- **Sub-module `deadtime_gen`:** takes `clk`, `rst_n`, `en`, `raw`, and outputs `pwm_h`/`pwm_l`.
  - Instantiated only under `PWM_DEADTIME_EN`.
  - Parameterised by `DEAD`.
- Carrier counter, duty latch and compare stay in `pwm_mod`.

## Test plan
- **Reset/disable:** `rst_n`=0 with en=1 → all outputs 0 immediately. Release with en=0 → outputs stay 0 and `sync` never pulses.
- **Midscale, macro off:** x=0, en=1 → `sync` every 510 cycles; `pwm_h` high 255 consecutive cycles per period; `pwm_l` the exact complement.
- **Extremes, macro off:**
  - x=−128 → `pwm_h` never 1 and `pwm_l` constantly 1.
  - x=127 → `pwm_h` high 509 of 510 cycles.
- **Update timing:** x steps from 0 to 64 mid-period → current period keeps 255 high cycles; the period after the next `sync` has 383 high cycles.
- **Dead time:** macro on, `DEAD`=4, x=0 → both outputs 0 for exactly 4 cycles at every transition; `pwm_h` high 251 and `pwm_l` high 251 per period; never both 1.
  - With x=−127 (raw pulse 1 cycle) → `pwm_h` never asserts.
- **Enable mid-period:** en dropped at `cnt`=100 → both outputs 0 on the next edge. Re-enable → `sync` on the first enabled edge's following cycle, and the period restarts from `cnt`=0.

Source files
------------

// File: rtl/pwm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pwm_pkg: shared types and constants for the center-aligned PWM modulator   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package pwm_pkg;

  localparam int                    PWM_DATA_W   = 8;
  localparam logic [PWM_DATA_W-1:0] PWM_CNT_MAX  = 8'hFF;
  localparam logic [PWM_DATA_W-1:0] PWM_DUTY_MID = 8'h80;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DEAD  = 2'd1,
    ST_DRIVE = 2'd2
  } dt_state_e;

  // Signed Q1.7 to offset binary (x + 128): flip the sign bit.
  function automatic logic [PWM_DATA_W-1:0] to_offset(input logic [PWM_DATA_W-1:0] s);
    return {~s[PWM_DATA_W-1], s[PWM_DATA_W-2:0]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/deadtime_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | deadtime_gen: dead-time inserter for the complementary PWM pair            |
// | Present only when PWM_DEADTIME_EN is defined.                              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`ifdef PWM_DEADTIME_EN
module deadtime_gen
  import pwm_pkg::*;
#(
  parameter int DEAD = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic raw,
  output logic pwm_h,
  output logic pwm_l
);

  localparam logic [3:0] c_dead = 4'(DEAD);

  dt_state_e  r_state;
  dt_state_e  w_state_nxt;
  logic [3:0] r_timer;
  logic [3:0] w_timer_nxt;
  logic       r_raw_d;
  logic       w_toggle;

  assign w_toggle = raw ^ r_raw_d;

  // A toggle always wins over timer expiry so pulses of DEAD cycles or less vanish.
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    if (!en) begin
      w_state_nxt = ST_IDLE;
      w_timer_nxt = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_DEAD;
          w_timer_nxt = c_dead;
        end
        ST_DEAD: begin
          if (w_toggle) begin
            w_timer_nxt = c_dead;
          end else if (r_timer <= 4'd1) begin
            w_state_nxt = ST_DRIVE;
            w_timer_nxt = '0;
          end else begin
            w_timer_nxt = r_timer - 4'd1;
          end
        end
        ST_DRIVE: begin
          if (w_toggle) begin
            w_state_nxt = ST_DEAD;
            w_timer_nxt = c_dead;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_timer_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_timer <= '0;
      r_raw_d <= 1'b0;
      pwm_h   <= 1'b0;
      pwm_l   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      r_raw_d <= raw;
      pwm_h   <= (w_state_nxt == ST_DRIVE) &  raw;
      pwm_l   <= (w_state_nxt == ST_DRIVE) & ~raw;
    end
  end

endmodule
`endif
`default_nettype wire

// File: rtl/pwm_mod.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pwm_mod: center-aligned PWM modulator, triangular carrier, regular sampling|
// | Optional dead-time insertion via PWM_DEADTIME_EN.                          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pwm_mod
  import pwm_pkg::*;
#(
  parameter int DEAD = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [PWM_DATA_W-1:0] x,
  output logic                  pwm_h,
  output logic                  pwm_l,
  output logic                  sync
);

  if (DEAD < 1 || DEAD > 15) begin : g_dead_range
    $error("pwm_mod: DEAD must lie in 1..15");
  end

  logic [PWM_DATA_W-1:0] r_cnt;
  logic                  r_dir_up;
  logic [PWM_DATA_W-1:0] r_duty;
  logic                  r_raw;
  logic                  w_valley;

  assign w_valley = (r_cnt == '0);

  // Carrier 0..255..1: 255 turns straight to 254, 1 turns via 0 back up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_dir_up <= 1'b1;
    end else if (!en) begin
      r_cnt    <= '0;
      r_dir_up <= 1'b1;
    end else if (r_dir_up) begin
      if (r_cnt == PWM_CNT_MAX) begin
        r_cnt    <= PWM_CNT_MAX - 8'd1;
        r_dir_up <= 1'b0;
      end else begin
        r_cnt <= r_cnt + 8'd1;
      end
    end else begin
      if (r_cnt == 8'd1) r_dir_up <= 1'b1;
      r_cnt <= r_cnt - 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_duty <= PWM_DUTY_MID;
      r_raw  <= 1'b0;
      sync   <= 1'b0;
    end else if (!en) begin
      r_raw <= 1'b0;
      sync  <= 1'b0;
    end else begin
      sync  <= w_valley;
      r_raw <= (r_duty > r_cnt);
      if (w_valley) r_duty <= to_offset(x);
    end
  end

`ifdef PWM_DEADTIME_EN
  deadtime_gen #(
    .DEAD (DEAD)
  ) u_deadtime (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .raw   (r_raw),
    .pwm_h (pwm_h),
    .pwm_l (pwm_l)
  );
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_h <= 1'b0;
      pwm_l <= 1'b0;
    end else begin
      pwm_h <=  r_raw & en;
      pwm_l <= ~r_raw & en;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pwm_mod.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pwm_mod: self-checking bench for pwm_mod against a phase-based model    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_pwm_mod;

  localparam int TB_DEAD = 4;
  localparam int PERIOD  = 510;
`ifdef PWM_DEADTIME_EN
  localparam bit DT  = 1'b1;
  localparam int WIN = TB_DEAD + 1;
`else
  localparam bit DT  = 1'b0;
  localparam int WIN = 1;
`endif
  localparam logic [4:0] WIN_MASK = 5'((1 << WIN) - 1);

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0;
  logic [7:0] x = 8'd0;
  logic       pwm_h, pwm_l, sync;

  int checks = 0;
  int errors = 0;

  pwm_mod #(.DEAD(TB_DEAD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .x     (x),
    .pwm_h (pwm_h),
    .pwm_l (pwm_l),
    .sync  (sync)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Carrier value at a given phase within the 510-cycle period.
  function automatic int cnt_of(input int ph);
    return (ph <= 255) ? ph : PERIOD - ph;
  endfunction

  function automatic int trim(input int n);
    if (!DT || n == 0 || n == PERIOD) return n;
    return (n > TB_DEAD) ? n - TB_DEAD : 0;
  endfunction

  function automatic int hi_of(input int d);
    return (d == 0) ? 0 : 2 * d - 1;
  endfunction

  // Reference model: phase since restart, latched duty, compare result and the
  // history of the ideal (dead-time free) outputs.
  int         m_ph = 0;
  int         m_duty = 128;
  logic       m_raw = 1'b0;
  logic       m_sync = 1'b0;
  logic       m_run = 1'b0;
  logic [4:0] m_hist_h = '0;
  logic [4:0] m_hist_l = '0;
  logic       exp_h, exp_l;

  assign exp_h = ((m_hist_h & WIN_MASK) == WIN_MASK);
  assign exp_l = ((m_hist_l & WIN_MASK) == WIN_MASK);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph <= 0; m_duty <= 128; m_raw <= 1'b0; m_sync <= 1'b0; m_run <= 1'b0;
      m_hist_h <= '0; m_hist_l <= '0;
    end else if (!en) begin
      m_ph <= 0; m_raw <= 1'b0; m_sync <= 1'b0; m_run <= 1'b0;
      m_hist_h <= {m_hist_h[3:0], 1'b0};
      m_hist_l <= {m_hist_l[3:0], 1'b0};
    end else begin
      m_run    <= 1'b1;
      m_sync   <= (cnt_of(m_ph) == 0);
      m_raw    <= (m_duty > cnt_of(m_ph));
      if (cnt_of(m_ph) == 0) m_duty <= int'($signed(x)) + 128;
      m_ph     <= (m_ph + 1) % PERIOD;
      m_hist_h <= {m_hist_h[3:0], m_raw};
      m_hist_l <= {m_hist_l[3:0], ~m_raw};
    end
  end

  // Per-cycle comparison plus per-period statistics, sampled on the falling edge.
  logic sd1 = 1'b0, sd2 = 1'b0, have_sync = 1'b0;
  int   nwin = 0, wd = 0, wd_prev = -1, wh = 0, wl = 0, gap = 0;

  always @(negedge clk) begin
    check("cyc_pwm_h", pwm_h, exp_h);
    check("cyc_pwm_l", pwm_l, exp_l);
    check("cyc_sync", sync, m_sync);
    check("never_both", pwm_h & pwm_l, 1'b0);
    sd1 <= sync;
    sd2 <= sd1;
    if (!m_run) begin
      nwin <= 0; wh <= 0; wl <= 0; have_sync <= 1'b0; gap <= 0; wd_prev <= -1;
    end else begin
      if (sync) begin
        if (have_sync) check("sync_period", gap, PERIOD);
        have_sync <= 1'b1;
        gap <= 1;
      end else begin
        gap <= gap + 1;
      end
      if (sd2) begin
        if (nwin >= 2 && (!DT || wd == wd_prev)) begin
          check("win_high_h", wh, trim(hi_of(wd)));
          check("win_high_l", wl, trim(PERIOD - hi_of(wd)));
        end
        nwin <= nwin + 1; wd_prev <= wd; wd <= m_duty;
        wh <= int'(pwm_h); wl <= int'(pwm_l);
      end else begin
        wh <= wh + int'(pwm_h); wl <= wl + int'(pwm_l);
      end
    end
  end

  task automatic measure(input int n, output int hc, output int lc);
    hc = 0; lc = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      hc += int'(pwm_h);
      lc += int'(pwm_l);
    end
  endtask

  task automatic wait_cnt_up(input int c);
    bit found = 1'b0;
    for (int k = 0; k < 1100 && !found; k++) begin
      @(negedge clk);
      if (m_run && m_ph == c) found = 1'b1;
    end
    check("wait_cnt", found, 1'b1);
  endtask

  initial begin
    int hc, lc, ns, gp;
    bit seen;
    en = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_pwm_h", pwm_h, 1'b0);
    check("rst_pwm_l", pwm_l, 1'b0);
    check("rst_sync", sync, 1'b0);

    // Release with en low: nothing moves.
    en = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ns = 0; hc = 0; lc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      ns += int'(sync); hc += int'(pwm_h); lc += int'(pwm_l);
    end
    check("dis_sync_cnt", ns, 0);
    check("dis_h_cnt", hc, 0);
    check("dis_l_cnt", lc, 0);

    // Midscale.
    x = 8'h00; en = 1'b1;
    repeat (3 * PERIOD + 20) @(negedge clk);
    measure(PERIOD, hc, lc);
    check("mid_h_cnt", hc, trim(255));
    check("mid_l_cnt", lc, trim(255));

    // Asynchronous reset mid-period.
    wait_cnt_up(40);
    #2 rst_n = 1'b0;
    #1;
    check("arst_pwm_h", pwm_h, 1'b0);
    check("arst_pwm_l", pwm_l, 1'b0);
    check("arst_sync", sync, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Extremes.
    x = 8'h80;
    repeat (2 * PERIOD + 10) @(negedge clk);
    measure(PERIOD, hc, lc);
    check("min_h_cnt", hc, 0);
    check("min_l_cnt", lc, PERIOD);
    x = 8'h7F;
    repeat (2 * PERIOD + 10) @(negedge clk);
    measure(PERIOD, hc, lc);
    check("max_h_cnt", hc, trim(509));
    check("max_l_cnt", lc, trim(1));
    x = 8'h81;
    repeat (2 * PERIOD + 10) @(negedge clk);
    measure(PERIOD, hc, lc);
    check("min1_h_cnt", hc, trim(1));

    // Mid-period update: window monitor expects 255 then 383.
    x = 8'h00;
    repeat (2 * PERIOD) @(negedge clk);
    wait_cnt_up(100);
    x = 8'd64;
    repeat (3 * PERIOD) @(negedge clk);

    // Random samples every cycle; only valley samples matter.
    for (int i = 0; i < 6 * PERIOD; i++) begin
      @(negedge clk);
      x = 8'($urandom_range(0, 255));
    end

    // Enable dropped at cnt 100, then re-enabled.
    wait_cnt_up(100);
    en = 1'b0;
    @(posedge clk); #1;
    check("drop_pwm_h", pwm_h, 1'b0);
    check("drop_pwm_l", pwm_l, 1'b0);
    check("drop_sync", sync, 1'b0);
    repeat (5) @(negedge clk);
    en = 1'b1;
    @(posedge clk); #1;
    check("reen_sync", sync, 1'b1);
    gp = 0; seen = 1'b0;
    for (int k = 0; k < 600 && !seen; k++) begin
      @(posedge clk); #1;
      gp++;
      if (sync) seen = 1'b1;
    end
    check("reen_period", gp, PERIOD);
    repeat (20) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
